y_motion_ctrl: RTL and testbench
================================

Y_MOTION_CTRL -- requirements
Module: y_motion_ctrl

Interface
REQ-001 SHALL have parameter Y_W, default 7, the width of the y coordinate.
REQ-002 SHALL have parameter Y_RESET, default 108, the y value after reset.
REQ-003 SHALL have parameter Y_MIN, default 0, the top screen limit.
REQ-004 SHALL have parameter Y_MAX, default 119, the bottom screen limit.
REQ-005 SHALL have parameter BJ_V0, default 9, the first big-jump rise step.
REQ-006 SHALL have parameter BJ_VEND, default 3, the last big-jump rise step.
REQ-007 SHALL have parameter BJ_SETTLE, default 2, the big-jump final down step.
REQ-008 SHALL have parameter SJ_V0, default 7, the first small-jump rise step.
REQ-009 SHALL have parameter DROP_VMAX, default 9, the last drop step.
REQ-010 SHALL have parameter DROP_SKIP, default 5, a drop step value omitted from the drop sequence.
REQ-011 SHALL have port clk, input, 1 bit: the clock.
REQ-012 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-013 SHALL have port tick, input, 1 bit: a one-clk frame-update enable.
REQ-014 SHALL have port key_n, input, 3 bits: asynchronous active-low buttons; [0] big jump, [1] small jump, [2] drop.
REQ-015 SHALL have port y, output, Y_W bits: the current vertical position.
REQ-016 SHALL have port move, output, 2 bits: the active move; 00 none, 01 big, 10 small, 11 drop.
REQ-017 SHALL have port busy, output, 1 bit: high while move is not 00.
REQ-018 SHALL have port move_done, output, 1 bit: a one-clk pulse on a move's final step.
REQ-019 SHALL have port reject, output, 1 bit: a one-clk pulse when a command is refused.
REQ-020 SHALL have port clamped, output, 1 bit: a one-clk pulse when y saturates.

Function
REQ-021 SHALL synchronise key_n through two flops and create a command only on a falling edge; a held key SHALL NOT repeat.
REQ-022 SHALL resolve simultaneous edges by priority key0 > key1 > key2.
REQ-023 SHALL start a command in IDLE on the clk after the edge; the first y step SHALL occur on the next tick.
REQ-024 SHALL store a command arriving while busy in a one-entry pending slot; while the slot is full, further commands SHALL be dropped silently.
REQ-025 SHALL start a pending command on the same clk as move_done, with no idle tick between moves.
REQ-026 SHALL change y only on clk edges with tick=1; the FSM SHALL NOT advance without tick.
REQ-027 SHALL use FSM states IDLE, BIG_UP, BIG_SETTLE, SMALL_UP, SMALL_DOWN, DROP.
REQ-028 SHALL run the big jump in BIG_UP, subtracting BJ_V0, BJ_V0-1, ..., BJ_VEND, then one tick in BIG_SETTLE adding BJ_SETTLE; net rise = sum(BJ_VEND..BJ_V0)-BJ_SETTLE (40 at defaults).
REQ-029 SHALL run the small jump in SMALL_UP, subtracting SJ_V0..0, then in SMALL_DOWN adding 1..SJ_V0; net displacement 0, 2*SJ_V0+1 ticks.
REQ-030 SHALL run the drop by adding 1..DROP_VMAX, omitting DROP_SKIP (40 at defaults).
REQ-031 SHALL reject a big jump if y - peak_rise < Y_MIN, where peak_rise = sum(BJ_VEND..BJ_V0).
REQ-032 SHALL reject a drop if y + drop_total > Y_MAX.
REQ-033 On a rejected command, y SHALL be unchanged, the FSM SHALL stay IDLE, and reject SHALL pulse for one clk; rejection SHALL be evaluated when the command starts, including a pending one.
REQ-034 SHALL compute steps in Y_W+1 signed bits and saturate the result to [Y_MIN,Y_MAX]; saturation SHALL pulse clamped, and the move SHALL continue.
REQ-035 SHALL assert move_done, return move to 00 (unless a pending command starts) and reset all step counters on a move's final tick.

Reset
REQ-036 On resetn low, immediately and also mid-move: y=Y_RESET, move=00, busy=0, move_done=0, reject=0, clamped=0, pending slot empty, sync flops=1 (released), state IDLE.
REQ-037 A key held low through reset release SHALL NOT generate a command.

Structure
REQ-038 SHALL place the move encodings (MV_NONE, MV_BIG, MV_SMALL, MV_DROP) and the FSM state enum in shared package y_motion_pkg.
REQ-039 SHALL implement key synchronisation, edge detection, priority and the pending slot in sub-module key_cmd_queue.

Verification
REQ-040 Reset, key0 pulse, 8 ticks -> y=99,91,84,78,73,69,66,68; move_done on the 8th tick.
REQ-041 y=108, key1 -> y=101,95,90,86,83,81,80,80,81,83,86,90,95,101,108; done on tick 15.
REQ-042 y=68, key2 -> y=69,71,74,78,84,91,99,108; done on tick 8. From y=108, key2 -> reject pulse, y stays 108, busy=0.
REQ-043 From y=28, key0 -> reject, y=28. From y=68, key0 -> ends at y=28, peak 26.
REQ-044 key1 at tick 3 of a big jump, then key2 at tick 4 -> small jump starts at move_done, key2 discarded, final y=68.
REQ-045 resetn low at tick 5 of a small jump -> y=108, busy=0 without clk; after release, no move until a new key edge.

Source files
------------

// File: rtl/y_motion_pkg.sv
// Shared move encodings, FSM states and parameter helpers for the y motion controller.
package y_motion_pkg;

    typedef enum logic [1:0] {
        MV_NONE  = 2'b00,
        MV_BIG   = 2'b01,
        MV_SMALL = 2'b10,
        MV_DROP  = 2'b11
    } move_t;

    typedef enum logic [2:0] {
        IDLE,
        BIG_UP,
        BIG_SETTLE,
        SMALL_UP,
        SMALL_DOWN,
        DROP
    } state_t;

    function automatic int sum_range(input int lo, input int hi);
        int s;
        s = 0;
        for (int v = lo; v <= hi; v++) begin
            s += v;
        end
        return s;
    endfunction

endpackage

// File: rtl/key_cmd_queue.sv
// Button synchroniser, falling-edge detector with fixed priority, and a one-entry pending slot.
module key_cmd_queue
    import y_motion_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] key_n_i,
    input  logic       take_i,
    output logic       cmd_valid_o,
    output move_t      cmd_o
);

    logic [2:0] sync1_q, sync2_q, prev_q;
    logic [1:0] settle_q;
    logic       slot_full_q, slot_full_d;
    move_t      slot_q, slot_d;
    logic [2:0] fall;
    logic       edge_valid;
    move_t      edge_cmd;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= 3'b111;
            sync2_q     <= 3'b111;
            prev_q      <= 3'b111;
            settle_q    <= 2'd0;
            slot_full_q <= 1'b0;
            slot_q      <= MV_NONE;
        end else begin
            sync1_q     <= key_n_i;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
            slot_full_q <= slot_full_d;
            slot_q      <= slot_d;
        end
    end

    always_comb begin
        // Edges are ignored until the chain has flushed, so a key held through reset is not seen.
        fall       = (settle_q == 2'd3) ? (prev_q & ~sync2_q) : 3'b000;
        edge_valid = |fall;
        if (fall[0]) begin
            edge_cmd = MV_BIG;
        end else if (fall[1]) begin
            edge_cmd = MV_SMALL;
        end else if (fall[2]) begin
            edge_cmd = MV_DROP;
        end else begin
            edge_cmd = MV_NONE;
        end

        cmd_valid_o = slot_full_q | edge_valid;
        cmd_o       = slot_full_q ? slot_q : edge_cmd;

        slot_full_d = slot_full_q;
        slot_d      = slot_q;
        if (take_i) begin
            slot_full_d = 1'b0;
            slot_d      = MV_NONE;
        end else if (edge_valid && !slot_full_q) begin
            slot_full_d = 1'b1;
            slot_d      = edge_cmd;
        end
    end

endmodule

// File: rtl/y_motion_ctrl.sv
// Vertical motion controller: big jump, small jump and drop trajectories stepped on frame ticks.
module y_motion_ctrl
    import y_motion_pkg::*;
#(
    parameter int Y_W       = 7,
    parameter int Y_RESET   = 108,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 119,
    parameter int BJ_V0     = 9,
    parameter int BJ_VEND   = 3,
    parameter int BJ_SETTLE = 2,
    parameter int SJ_V0     = 7,
    parameter int DROP_VMAX = 9,
    parameter int DROP_SKIP = 5
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           tick,
    input  logic [2:0]     key_n,
    output logic [Y_W-1:0] y,
    output logic [1:0]     move,
    output logic           busy,
    output logic           move_done,
    output logic           reject,
    output logic           clamped
);

    localparam int PEAK_RISE  = sum_range(BJ_VEND, BJ_V0);
    localparam int DROP_TOTAL = sum_range(1, DROP_VMAX)
                              - (((DROP_SKIP >= 1) && (DROP_SKIP <= DROP_VMAX)) ? DROP_SKIP : 0);

    localparam logic [Y_W-1:0] STEP_ONE    = Y_W'(1);
    localparam logic [Y_W-1:0] STEP_TWO    = Y_W'(2);
    localparam logic [Y_W-1:0] BJ_V0_W     = Y_W'(BJ_V0);
    localparam logic [Y_W-1:0] BJ_VEND_W   = Y_W'(BJ_VEND);
    localparam logic [Y_W-1:0] SJ_V0_W     = Y_W'(SJ_V0);
    localparam logic [Y_W-1:0] DROP_VMAX_W = Y_W'(DROP_VMAX);
    localparam logic [Y_W-1:0] DROP_SKIP_W = Y_W'(DROP_SKIP);
    localparam logic [Y_W-1:0] DROP_FIRST  = (DROP_SKIP == 1) ? STEP_TWO : STEP_ONE;
    localparam logic [Y_W-1:0] Y_MIN_W     = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0] Y_MAX_W     = Y_W'(Y_MAX);
    localparam logic signed [Y_W:0] Y_MIN_S     = (Y_W+1)'(Y_MIN);
    localparam logic signed [Y_W:0] Y_MAX_S     = (Y_W+1)'(Y_MAX);
    localparam logic signed [Y_W:0] BJ_SETTLE_S = (Y_W+1)'(BJ_SETTLE);

    state_t         state_q, state_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [Y_W-1:0] step_q, step_d;
    logic           done_q, done_d;
    logic           reject_q, reject_d;
    logic           clamped_q, clamped_d;
    logic           take, cmd_valid, last_step;
    move_t          cmd, move_w;
    logic signed [Y_W:0] delta, y_sum;

    key_cmd_queue u_key_cmd_queue (
        .clk         (clk),
        .resetn      (resetn),
        .key_n_i     (key_n),
        .take_i      (take),
        .cmd_valid_o (cmd_valid),
        .cmd_o       (cmd)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            y_q       <= Y_W'(Y_RESET);
            step_q    <= '0;
            done_q    <= 1'b0;
            reject_q  <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            step_q    <= step_d;
            done_q    <= done_d;
            reject_q  <= reject_d;
            clamped_q <= clamped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        step_d    = step_q;
        done_d    = 1'b0;
        reject_d  = 1'b0;
        clamped_d = 1'b0;
        take      = 1'b0;
        last_step = 1'b0;
        delta     = '0;

        if (tick) begin
            unique case (state_q)
                BIG_UP: begin
                    delta = -$signed({1'b0, step_q});
                    if (step_q == BJ_VEND_W) state_d = BIG_SETTLE;
                    else                     step_d  = step_q - STEP_ONE;
                end
                BIG_SETTLE: begin
                    delta     = BJ_SETTLE_S;
                    last_step = 1'b1;
                end
                SMALL_UP: begin
                    delta = -$signed({1'b0, step_q});
                    if (step_q == '0) begin
                        state_d = SMALL_DOWN;
                        step_d  = STEP_ONE;
                    end else begin
                        step_d = step_q - STEP_ONE;
                    end
                end
                SMALL_DOWN: begin
                    delta = $signed({1'b0, step_q});
                    if (step_q == SJ_V0_W) last_step = 1'b1;
                    else                   step_d    = step_q + STEP_ONE;
                end
                DROP: begin
                    delta = $signed({1'b0, step_q});
                    if (step_q == DROP_VMAX_W)                 last_step = 1'b1;
                    else if (step_q + STEP_ONE == DROP_SKIP_W) step_d    = step_q + STEP_TWO;
                    else                                       step_d    = step_q + STEP_ONE;
                end
                default: ;
            endcase
        end

        y_sum = $signed({1'b0, y_q}) + delta;
        if (tick && (state_q != IDLE)) begin
            if (y_sum < Y_MIN_S) begin
                y_d       = Y_MIN_W;
                clamped_d = 1'b1;
            end else if (y_sum > Y_MAX_S) begin
                y_d       = Y_MAX_W;
                clamped_d = 1'b1;
            end else begin
                y_d = y_sum[Y_W-1:0];
            end
        end

        if (last_step) begin
            done_d  = 1'b1;
            state_d = IDLE;
            step_d  = '0;
        end

        // A pending command starts against the y produced by the final step.
        if (((state_q == IDLE) || last_step) && cmd_valid) begin
            take = 1'b1;
            unique case (cmd)
                MV_BIG: begin
                    if (int'(y_d) - PEAK_RISE < Y_MIN) begin
                        reject_d = 1'b1;
                    end else begin
                        state_d = BIG_UP;
                        step_d  = BJ_V0_W;
                    end
                end
                MV_SMALL: begin
                    state_d = SMALL_UP;
                    step_d  = SJ_V0_W;
                end
                MV_DROP: begin
                    if (int'(y_d) + DROP_TOTAL > Y_MAX) begin
                        reject_d = 1'b1;
                    end else begin
                        state_d = DROP;
                        step_d  = DROP_FIRST;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        unique case (state_q)
            BIG_UP, BIG_SETTLE:   move_w = MV_BIG;
            SMALL_UP, SMALL_DOWN: move_w = MV_SMALL;
            DROP:                 move_w = MV_DROP;
            default:              move_w = MV_NONE;
        endcase
    end

    assign y         = y_q;
    assign move      = move_w;
    assign busy      = (state_q != IDLE);
    assign move_done = done_q;
    assign reject    = reject_q;
    assign clamped   = clamped_q;

endmodule

// File: tb/tb_y_motion_ctrl.sv
// Bench for y_motion_ctrl: directed scenarios plus random command sequences against a trajectory model.
module tb_y_motion_ctrl;

    localparam int Y_MIN     = 0;
    localparam int Y_MAX     = 119;
    localparam int BJ_V0     = 9;
    localparam int BJ_VEND   = 3;
    localparam int BJ_SETTLE = 2;
    localparam int SJ_V0     = 7;
    localparam int DROP_VMAX = 9;
    localparam int DROP_SKIP = 5;

    logic       clk = 1'b0;
    logic       resetn, tick, tick_lo;
    logic [2:0] key_n, key_lo_n;
    logic [6:0] y, y_lo;
    logic [1:0] move, move_lo;
    logic       busy, move_done, reject, clamped;
    logic       busy_lo, done_lo, reject_lo, clamped_lo;

    int tests = 0, fails = 0;
    int rej_cnt = 0, clamp_cnt = 0, done_cnt = 0, clamp_lo_cnt = 0;
    int model_y;
    int exp_q[$];

    always #5 clk = ~clk;

    y_motion_ctrl u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .tick      (tick),
        .key_n     (key_n),
        .y         (y),
        .move      (move),
        .busy      (busy),
        .move_done (move_done),
        .reject    (reject),
        .clamped   (clamped)
    );

    // Second instance starting low so that saturation at the top limit is reachable.
    y_motion_ctrl #(.Y_RESET(20)) u_low (
        .clk       (clk),
        .resetn    (resetn),
        .tick      (tick_lo),
        .key_n     (key_lo_n),
        .y         (y_lo),
        .move      (move_lo),
        .busy      (busy_lo),
        .move_done (done_lo),
        .reject    (reject_lo),
        .clamped   (clamped_lo)
    );

    always @(negedge clk) begin
        if (reject)     rej_cnt++;
        if (clamped)    clamp_cnt++;
        if (move_done)  done_cnt++;
        if (clamped_lo) clamp_lo_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_step(inout int yy, input int d, inout int nc);
        yy += d;
        if (yy < Y_MIN) begin
            yy = Y_MIN;
            nc++;
        end else if (yy > Y_MAX) begin
            yy = Y_MAX;
            nc++;
        end
        exp_q.push_back(yy);
    endtask

    // Expected y after each tick of a move, the reject decision and the number of saturations.
    task automatic model_move(input int cmd, input int y0, output bit rej, output int nc);
        int yy, peak, total;
        yy = y0;
        nc = 0;
        rej = 1'b0;
        exp_q.delete();
        peak = 0;
        for (int v = BJ_VEND; v <= BJ_V0; v++) peak += v;
        total = 0;
        for (int v = 1; v <= DROP_VMAX; v++) if (v != DROP_SKIP) total += v;
        case (cmd)
            0: begin
                if (y0 - peak < Y_MIN) rej = 1'b1;
                else begin
                    for (int v = BJ_V0; v >= BJ_VEND; v--) push_step(yy, -v, nc);
                    push_step(yy, BJ_SETTLE, nc);
                end
            end
            1: begin
                for (int v = SJ_V0; v >= 0; v--) push_step(yy, -v, nc);
                for (int v = 1; v <= SJ_V0; v++) push_step(yy, v, nc);
            end
            default: begin
                if (y0 + total > Y_MAX) rej = 1'b1;
                else for (int v = 1; v <= DROP_VMAX; v++) if (v != DROP_SKIP) push_step(yy, v, nc);
            end
        endcase
    endtask

    task automatic press(input int k);
        key_n[k] = 1'b0;
        repeat (5) @(negedge clk);
        key_n[k] = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic run_move(input int cmd);
        bit rej;
        int nc, r0, c0, d0;
        model_move(cmd, model_y, rej, nc);
        r0 = rej_cnt;
        c0 = clamp_cnt;
        d0 = done_cnt;
        press(cmd);
        if (rej) begin
            chk("reject_pulse", rej_cnt - r0, 1);
            chk("reject_y", int'(y), model_y);
            chk("reject_busy", int'(busy), 0);
        end else begin
            chk("start_move", int'(move), cmd + 1);
            for (int i = 0; i < exp_q.size(); i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                do_tick();
                chk("traj_y", int'(y), exp_q[i]);
                if (i == exp_q.size() - 1) begin
                    chk("done_pulse", int'(move_done), 1);
                    chk("done_busy", int'(busy), 0);
                end else begin
                    chk("mid_busy", int'(busy), 1);
                end
            end
            model_y = exp_q[exp_q.size() - 1];
            @(negedge clk);
            chk("done_count", done_cnt - d0, 1);
            chk("clamp_count", clamp_cnt - c0, nc);
            chk("move_idle", int'(move), 0);
        end
    endtask

    initial begin
        bit rej;
        int nc, d0, c0;
        int big_q[$];

        resetn   = 1'b1;
        tick     = 1'b0;
        tick_lo  = 1'b0;
        key_n    = 3'b110;
        key_lo_n = 3'b111;
        #1 resetn = 1'b0;
        #1;
        chk("rst_y", int'(y), 108);
        chk("rst_busy", int'(busy), 0);
        chk("rst_move", int'(move), 0);
        chk("rst_done", int'(move_done), 0);
        chk("rst_reject", int'(reject), 0);
        chk("rst_clamped", int'(clamped), 0);
        chk("rst_y_lo", int'(y_lo), 20);

        // key0 held low through reset release must not start a move
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_key_busy", int'(busy), 0);
        chk("held_key_y", int'(y), 108);
        key_n = 3'b111;
        repeat (4) @(negedge clk);
        model_y = 108;

        run_move(0);
        chk("big_end_y", int'(y), 68);
        run_move(2);
        chk("drop_end_y", int'(y), 108);
        run_move(2);
        run_move(1);
        chk("small_end_y", int'(y), 108);

        // small jump queued during a big jump, drop arriving while the slot is full is lost
        model_move(0, model_y, rej, nc);
        big_q = exp_q;
        d0 = done_cnt;
        press(0);
        for (int i = 0; i < big_q.size(); i++) begin
            if (i == 3) press(1);
            if (i == 4) press(2);
            do_tick();
            chk("pend_big_y", int'(y), big_q[i]);
        end
        chk("pend_done", int'(move_done), 1);
        chk("pend_start_move", int'(move), 2);
        chk("pend_busy", int'(busy), 1);
        model_move(1, big_q[big_q.size() - 1], rej, nc);
        for (int i = 0; i < exp_q.size(); i++) begin
            do_tick();
            chk("pend_small_y", int'(y), exp_q[i]);
        end
        chk("pend_small_done", int'(move_done), 1);
        repeat (10) @(negedge clk);
        chk("dropped_cmd_busy", int'(busy), 0);
        chk("pend_done_count", done_cnt - d0, 2);
        chk("pend_final_y", int'(y), 68);
        model_y = 68;

        run_move(0);
        chk("big_low_y", int'(y), 28);
        run_move(0);

        // asynchronous reset in the middle of a small jump
        press(1);
        repeat (5) do_tick();
        resetn = 1'b0;
        #1;
        chk("midrst_y", int'(y), 108);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_move", int'(move), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        chk("postrst_busy", int'(busy), 0);
        chk("postrst_y", int'(y), 108);
        model_y = 108;

        // saturation on the low-start instance: the move keeps running through clamped steps
        model_move(1, 20, rej, nc);
        c0 = clamp_lo_cnt;
        key_lo_n[1] = 1'b0;
        repeat (5) @(negedge clk);
        key_lo_n[1] = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            tick_lo = 1'b1;
            @(negedge clk);
            tick_lo = 1'b0;
            chk("lo_traj_y", int'(y_lo), exp_q[i]);
        end
        chk("lo_done", int'(done_lo), 1);
        @(negedge clk);
        chk("lo_clamp_count", clamp_lo_cnt - c0, nc);
        chk("lo_busy", int'(busy_lo), 0);

        repeat (20) run_move(int'($urandom_range(0, 2)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
